// File: rtl/mmio_pkg.sv
// Shared register map and state encoding for the MMIO console peripheral.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mmio_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;

    // Byte offsets inside the 32-byte window, compared against addr[4:0]
    localparam logic [4:0] OFF_CONSOLE = 5'h00;
    localparam logic [4:0] OFF_STATUS  = 5'h04;
    localparam logic [4:0] OFF_TOHOST  = 5'h08;
    localparam logic [4:0] OFF_CYCLE   = 5'h10;

    // STATUS layout: bit0 full, bit1 empty, occupancy count from bit2 upward.
    // An idle, empty console therefore reads back as 0x2.
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_CNT_LSB   = 2;

    // RUN: normal operation; DRAIN: exit requested, waiting for the FIFO to empty;
    // TRAPPED: run finished, sticky until reset.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_TRAPPED = 2'd2
    } run_state_t;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Synchronous FIFO with occupancy count, used as the console output queue.
// Latency: a pushed entry is visible at the head one clock after the push.
// Backpressure: push ignored while full, pop ignored while empty; caller gates on full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are meaningless once the pointers clear
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mmio_console.sv
// Console/tohost MMIO peripheral: byte console FIFO, status, cycle counter, exit trap.
// Latency: loads return one clock after d_re; console bytes reach out_data one clock after the store.
// Backpressure: d_stall holds a console store while the FIFO is full; out_valid/out_ready drains the FIFO.
module mmio_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic        d_re,
    output logic        d_hit,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        trap,
    output logic [30:0] trap_code
);

    run_state_t       state;
    run_state_t       state_nxt;
    logic [4:0]       offset;
    logic             accepting;
    logic             con_wr;
    logic             toh_wr;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word;
    logic [31:0]      rd_val;
    logic [31:0]      cycle_cnt;

    assign offset    = d_addr[4:0];
    assign d_hit     = (d_addr[31:5] == BASE_ADDR[31:5]);
    // Once an exit is requested every further console/tohost store is silently dropped
    assign accepting = (state == ST_RUN);
    assign con_wr    = d_we && d_hit && (offset == OFF_CONSOLE) && accepting;
    assign toh_wr    = d_we && d_hit && (offset == OFF_TOHOST) && accepting && d_wdata[0];
    // Stall looks only at the registered full flag, so a same-cycle pop does not release it
    assign d_stall   = con_wr && fifo_full;
    assign fifo_push = con_wr && !fifo_full;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign trap      = (state == ST_TRAPPED);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (d_wdata[7:0]),
        .pop      (fifo_pop),
        .head_dat (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Exit state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Exit sequencing: request, wait for the console to drain, then trap for good
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (toh_wr) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_nxt = ST_TRAPPED;
            ST_TRAPPED: state_nxt = ST_TRAPPED;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Exit code captured with the accepted tohost store
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       trap_code <= '0;
        else if (toh_wr) trap_code <= d_wdata[31:1];
    end

    // Free-running cycle counter, wraps through zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    // Assemble STATUS and select the load data source
    always_comb begin
        status_word                             = '0;
        status_word[STAT_FULL_BIT]              = fifo_full;
        status_word[STAT_EMPTY_BIT]             = fifo_empty;
        status_word[STAT_CNT_LSB +: CNT_W]      = fifo_count;
        rd_val = '0;
        case (offset)
            OFF_STATUS: rd_val = status_word;
            OFF_CYCLE:  rd_val = cycle_cnt;
            default:    rd_val = '0;
        endcase
    end

    // Load data register: captures pre-edge state, holds between loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               d_rdata <= '0;
        else if (d_re && d_hit)  d_rdata <= rd_val;
    end

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: console byte stream via a scoreboard queue,
// register reads, stall/full behaviour, tohost trap timing, cycle counter and async reset.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_mmio_console;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_CON  = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_TOH  = BASE + 32'h08;
    localparam logic [31:0] A_RSV  = BASE + 32'h0C;
    localparam logic [31:0] A_CYC  = BASE + 32'h10;
    localparam logic [31:0] A_OUT  = 32'h2000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic        d_re;
    logic        d_hit;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        trap;
    logic [30:0] trap_code;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [7:0]  exp_q[$];

    mmio_console dut (
        .clk       (clk),
        .reset     (reset),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_re      (d_re),
        .d_hit     (d_hit),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .trap      (trap),
        .trap_code (trap_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake pops the oldest expected byte
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            n_pops++;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    // All tasks start and end on a falling edge
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
        d_addr = addr;
        d_re   = 1'b1;
        @(negedge clk);
        d_re   = 1'b0;
        val    = d_rdata;
    endtask

    task automatic console_put(input logic [7:0] b, input bit accepted);
        d_addr  = A_CON;
        d_wdata = {24'h0, b};
        d_we    = 1'b1;
        #1;
        chk("put_no_stall", 32'(d_stall), 32'd0);
        if (accepted) exp_q.push_back(b);
        @(negedge clk);
        d_we = 1'b0;
    endtask

    task automatic tohost_put(input logic [31:0] val);
        d_addr  = A_TOH;
        d_wdata = val;
        d_we    = 1'b1;
        @(negedge clk);
        d_we = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (out_valid || exp_q.size() != 0); i++) @(negedge clk);
        chk("drain_valid_low", 32'(out_valid), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    // Reset asserted mid-cycle so the asynchronous clear is observable before any clock edge
    task automatic apply_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_trap", 32'(trap), 32'd0);
        chk("rst_async_rdata", d_rdata, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic [31:0] c1;
        logic [31:0] c2;
        int          pops0;

        reset = 1'b1; d_addr = A_CON; d_wdata = '0; d_we = 1'b0; d_re = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_rdata", d_rdata, 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        chk("reset_code", 32'(trap_code), 32'd0);
        chk("reset_stall", 32'(d_stall), 32'd0);
        chk("hit_inside", 32'(d_hit), 32'd1);
        d_addr = A_OUT; #1;
        chk("hit_outside", 32'(d_hit), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: "Hi" streams out one byte per cycle
        out_ready = 1'b1;
        pops0 = n_pops;
        console_put(8'h48, 1'b1);
        console_put(8'h69, 1'b1);
        @(negedge clk); #3;
        chk("hi_pop_count", 32'(n_pops - pops0), 32'd2);
        chk("hi_drained", 32'(out_valid), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        bus_read(A_STAT, rv);
        chk("status_empty", rv, 32'h2);
        bus_read(A_RSV, rv);
        chk("reserved_read", rv, 32'h0);
        bus_read(A_STAT, rv);
        bus_read(A_OUT, rv);
        chk("miss_read_holds", rv, 32'h2);

        // 2: fill to capacity, 17th store stalls until a pop
        for (int i = 0; i < 16; i++) console_put(8'(8'h40 + i), 1'b1);
        bus_read(A_STAT, rv);
        chk("status_full", rv, 32'h41);
        d_addr = A_CON; d_wdata = 32'h7A; d_we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; chk("stall_full", 32'(d_stall), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1; chk("stall_during_pop", 32'(d_stall), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #1; chk("stall_released", 32'(d_stall), 32'd0);
        exp_q.push_back(8'h7A);
        @(negedge clk);
        d_we = 1'b0;
        bus_read(A_STAT, rv);
        chk("status_refull", rv, 32'h41);
        drain();

        // 3: trap follows the last pop by exactly one cycle
        console_put(8'h31, 1'b1);
        console_put(8'h32, 1'b1);
        console_put(8'h33, 1'b1);
        tohost_put(32'h0000_0001);
        chk("drain_trap_low0", 32'(trap), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("drain_trap_low", 32'(trap), 32'd0);
        end
        chk("drain_fifo_empty", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("drain_trap_high", 32'(trap), 32'd1);
        chk("drain_code", 32'(trap_code), 32'd0);
        out_ready = 1'b0;

        // 4: reset clears trap; empty FIFO traps on the next cycle; later stores dropped
        apply_reset();
        @(negedge clk);
        tohost_put(32'h0000_0002);
        repeat (3) @(negedge clk);
        chk("tohost_bit0_clear", 32'(trap), 32'd0);
        tohost_put(32'h0000_0055);
        chk("empty_trap_low", 32'(trap), 32'd0);
        @(negedge clk);
        chk("empty_trap_high", 32'(trap), 32'd1);
        chk("empty_code", 32'(trap_code), 32'h2A);
        console_put(8'h5A, 1'b0);
        tohost_put(32'h0000_0007);
        @(negedge clk);
        chk("post_trap_valid", 32'(out_valid), 32'd0);
        chk("post_trap_code", 32'(trap_code), 32'h2A);
        chk("post_trap_sticky", 32'(trap), 32'd1);
        bus_read(A_STAT, rv);
        chk("post_trap_status", rv, 32'h2);

        // 5: cycle counter spacing and wrap
        bus_read(A_CYC, c1);
        repeat (9) @(negedge clk);
        bus_read(A_CYC, c2);
        chk("cycle_delta", c2 - c1, 32'd10);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        release dut.cycle_cnt;
        bus_read(A_CYC, rv);
        chk("cycle_max", rv, 32'hFFFF_FFFF);
        bus_read(A_CYC, rv);
        chk("cycle_wrap", rv, 32'h0);

        // 6: reset with a half-full FIFO discards its contents
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) console_put(8'(8'hA0 + i), 1'b1);
        bus_read(A_STAT, rv);
        chk("status_half", rv, 32'h20);
        apply_reset();
        @(negedge clk);
        bus_read(A_STAT, rv);
        chk("status_after_reset", rv, 32'h2);
        chk("valid_after_reset", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
